// File: rtl/muldiv_ctrl.sv
// Iterative unsigned 32x32 multiply / 32/32 divide controller.
// One bit per cycle, fixed 32-cycle RUN phase, divide-by-zero short-circuits straight to DONE.
module muldiv_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        OP,
    input  logic [31:0] OPND_A,
    input  logic [31:0] OPND_B,
    input  logic        ABORT,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        DIV_ZERO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        op_q;
    logic [31:0] m_q;        // multiplicand for MULTU, divisor for DIVU
    logic [4:0]  cnt;
    logic [63:0] work;       // MULTU: {partial product, multiplier}; DIVU: {remainder, dividend/quotient}
    logic [63:0] work_step;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic        last_iter;
    logic        start_div_zero;

    assign last_iter      = (cnt == 5'd31);
    assign start_div_zero = OP && (OPND_B == 32'd0);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (START) state_next = start_div_zero ? S_DONE : S_RUN;
            S_RUN: begin
                if (ABORT)          state_next = S_IDLE;
                else if (last_iter) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // One iteration of shift-add multiply or restoring division.
    always_comb begin
        mul_sum   = {1'b0, work[63:32]} + {1'b0, m_q};
        div_trial = {work[63:32], work[31]} - {1'b0, m_q};
        work_step = work;
        if (!op_q) begin
            if (work[0]) work_step = {mul_sum, work[31:1]};
            else         work_step = {1'b0, work[63:1]};
        end else begin
            // Minuend is below twice the divisor, so bit 32 is a clean borrow flag.
            if (!div_trial[32]) work_step = {div_trial[31:0], work[30:0], 1'b1};
            else                work_step = {work[62:0], 1'b0};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q     <= 1'b0;
            m_q      <= 32'd0;
            cnt      <= 5'd0;
            work     <= 64'd0;
            HI       <= 32'd0;
            LO       <= 32'd0;
            DIV_ZERO <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        op_q <= OP;
                        m_q  <= OP ? OPND_B : OPND_A;
                        work <= {32'd0, (OP ? OPND_A : OPND_B)};
                        cnt  <= 5'd0;
                        if (start_div_zero) begin
                            HI       <= OPND_A;
                            LO       <= 32'hFFFF_FFFF;
                            DIV_ZERO <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!ABORT) begin
                        work <= work_step;
                        cnt  <= cnt + 5'd1;
                        if (last_iter) begin
                            HI       <= work_step[63:32];
                            LO       <= work_step[31:0];
                            DIV_ZERO <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state != S_IDLE);
    assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: cycle-schedule reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_muldiv_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        OP = 1'b0;
    logic [31:0] OPND_A = 32'd0;
    logic [31:0] OPND_B = 32'd0;
    logic        ABORT = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DIV_ZERO;

    int tests = 0;
    int fails = 0;

    muldiv_ctrl dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .OP       (OP),
        .OPND_A   (OPND_A),
        .OPND_B   (OPND_B),
        .ABORT    (ABORT),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .HI       (HI),
        .LO       (LO),
        .DIV_ZERO (DIV_ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted operation occupies a fixed window of cycles;
    // results are computed with plain arithmetic and published at the DONE cycle.
    int          m_cyc = 0;
    int          m_done_cyc = 0;
    bit          m_active = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    logic        m_dz = 1'b0, p_dz = 1'b0;
    logic [63:0] prod;

    always @(posedge CLK) begin
        if (RESET) begin
            m_active = 1'b0;
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_dz = 1'b0;
            m_valid = 1'b1;
        end else if (!m_active || m_cyc > m_done_cyc) begin
            if (START) begin
                m_active = 1'b1;
                if (OP && OPND_B == 32'd0) begin
                    p_hi = OPND_A;
                    p_lo = 32'hFFFF_FFFF;
                    p_dz = 1'b1;
                    m_done_cyc = m_cyc + 1;
                end else begin
                    p_dz = 1'b0;
                    m_done_cyc = m_cyc + 33;
                    if (OP) begin
                        p_hi = OPND_A % OPND_B;
                        p_lo = OPND_A / OPND_B;
                    end else begin
                        prod = 64'(OPND_A) * 64'(OPND_B);
                        p_hi = prod[63:32];
                        p_lo = prod[31:0];
                    end
                end
            end
        end else if (m_cyc < m_done_cyc && ABORT) begin
            m_active = 1'b0;
        end
        m_cyc++;
        if (m_active && m_cyc == m_done_cyc) begin
            m_hi = p_hi;
            m_lo = p_lo;
            m_dz = p_dz;
        end
        #1;
        if (m_valid) begin
            check("model BUSY", 64'(BUSY), 64'(m_active && m_cyc <= m_done_cyc));
            check("model DONE", 64'(DONE), 64'(m_active && m_cyc == m_done_cyc));
            check("model HI", 64'(HI), 64'(m_hi));
            check("model LO", 64'(LO), 64'(m_lo));
            check("model DIV_ZERO", 64'(DIV_ZERO), 64'(m_dz));
        end
    end

    task automatic step();
        @(negedge CLK);
    endtask

    // Issue one operation from IDLE, wait (bounded) for DONE, check literals.
    task automatic run_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int k;
        START = 1'b1; OP = op; OPND_A = a; OPND_B = b;
        step();
        START = 1'b0;
        k = 1;
        while (!DONE && k < 40) begin
            step();
            k++;
        end
        check({tag, " latency"}, 64'(k), 64'(exp_lat));
        check({tag, " HI"}, 64'(HI), 64'(exp_hi));
        check({tag, " LO"}, 64'(LO), 64'(exp_lo));
        check({tag, " DIV_ZERO"}, 64'(DIV_ZERO), 64'(exp_dz));
        step();
        check({tag, " DONE one cycle"}, 64'(DONE), 64'd0);
        check({tag, " idle after"}, 64'(BUSY), 64'd0);
    endtask

    initial begin
        int ndone;
        int prev;

        step();
        step();
        RESET = 1'b0;
        check("reset BUSY", 64'(BUSY), 64'd0);
        check("reset DONE", 64'(DONE), 64'd0);
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);
        check("reset DIV_ZERO", 64'(DIV_ZERO), 64'd0);

        run_op("mul max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div 100/7", 1'b1, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
        run_op("div by zero", 1'b1, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        run_op("mul 3*5", 1'b0, 32'd3, 32'd5, 33, 32'd0, 32'd15, 1'b0);

        // Abort mid-run; a START inside RUN must be neither taken nor queued.
        START = 1'b1; OP = 1'b0; OPND_A = 32'd6; OPND_B = 32'd7;
        step();
        START = 1'b0;
        repeat (4) step();
        START = 1'b1; OP = 1'b1; OPND_A = 32'd9; OPND_B = 32'd9;
        step();
        START = 1'b0;
        repeat (4) step();
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        check("abort BUSY", 64'(BUSY), 64'd0);
        check("abort DONE", 64'(DONE), 64'd0);
        check("abort HI kept", 64'(HI), 64'd0);
        check("abort LO kept", 64'(LO), 64'd15);
        repeat (30) step();
        check("abort no restart", 64'(BUSY), 64'd0);
        check("abort LO still kept", 64'(LO), 64'd15);

        // Reset in the middle of a divide.
        START = 1'b1; OP = 1'b1; OPND_A = 32'd1000; OPND_B = 32'd3;
        step();
        START = 1'b0;
        repeat (19) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("midrun reset BUSY", 64'(BUSY), 64'd0);
        check("midrun reset DONE", 64'(DONE), 64'd0);
        check("midrun reset HI", 64'(HI), 64'd0);
        check("midrun reset LO", 64'(LO), 64'd0);
        run_op("div 9/3", 1'b1, 32'd9, 32'd3, 33, 32'd0, 32'd3, 1'b0);

        // START held high: DONE pulses every 34 cycles.
        START = 1'b1; OP = 1'b0; OPND_A = $urandom; OPND_B = $urandom;
        ndone = 0;
        prev = 0;
        for (int c = 1; c <= 110; c++) begin
            step();
            if (DONE) begin
                if (ndone == 0) check("stream first done", 64'(c), 64'd33);
                else            check("stream spacing", 64'(c - prev), 64'd34);
                prev = c;
                ndone++;
            end
        end
        START = 1'b0;
        check("stream done count", 64'(ndone), 64'd3);

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            RESET  = ($urandom_range(0, 299) == 0);
            START  = ($urandom_range(0, 2) == 0);
            OP     = 1'($urandom_range(0, 1));
            OPND_A = $urandom;
            case ($urandom_range(0, 7))
                0:       OPND_B = 32'd0;
                1, 2:    OPND_B = 32'($urandom_range(1, 15));
                3:       OPND_B = OPND_A;
                default: OPND_B = $urandom;
            endcase
            ABORT  = ($urandom_range(0, 99) == 0);
            step();
        end
        RESET = 1'b0; START = 1'b0; ABORT = 1'b0;
        repeat (40) step();
        check("final idle", 64'(BUSY), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
